// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding, record tag and width derivations for tdc_multi.
package tdc_pkg;
    typedef enum logic [2:0] {IDLE, RUN, SETTLE, EMIT, REARM} state_e;
    localparam logic [3:0] REC_TAG = 4'b0101;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int data_w(input int n, input int cw, input int fw);
        return ch_w(n) + 1 + cw + 2 * fw + 4;
    endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser for an asynchronous level plus rising-edge detect.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic edge_o
);
    logic meta_q, sync_q, prev_q;
    always_ff @(posedge clk)
        if (!reset) {meta_q, sync_q, prev_q} <= '0;
        else {meta_q, sync_q, prev_q} <= {async_i, meta_q, sync_q};
    assign sync_o = sync_q;
    assign edge_o = sync_q & ~prev_q;
endmodule

// File: rtl/tdc_multi.sv
// tdc_multi: multi-channel time-to-digital converter; one start, NUM_CH stops,
// emits one {ch, hit, coarse, fine_start, fine_stop, tag} record per channel.
module tdc_multi
    import tdc_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int COARSE_W   = 16,
    parameter int FINE_W     = 10,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 2**COARSE_W - 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [NUM_CH-1:0]                           stop,
    input  logic [FINE_W-1:0]                           fine_start,
    input  logic [NUM_CH*FINE_W-1:0]                    fine_stop,
    output logic                                        fine_clear,
    output logic                                        busy,
    output logic [data_w(NUM_CH, COARSE_W, FINE_W)-1:0] data,
    output logic                                        valid,
    input  logic                                        ready
);
    localparam int CH_W = ch_w(NUM_CH);

    state_e                           state_q, state_d;
    logic [COARSE_W-1:0]              coarse_q, coarse_d;
    logic [NUM_CH-1:0]                hit_q, hit_d, new_hit;
    logic [NUM_CH-1:0][COARSE_W-1:0]  lat_q, lat_d;
    logic [FINE_W-1:0]                fs_q, fs_d;
    logic [NUM_CH-1:0][FINE_W-1:0]    fst_q, fst_d;
    logic [3:0]                       settle_q, settle_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic                             start_sync, start_edge, at_to;
    logic [NUM_CH-1:0]                stop_sync, stop_edge;

    sync_edge u_start (.clk(clk), .reset(reset), .async_i(start), .sync_o(start_sync), .edge_o(start_edge));
    for (genvar i = 0; i < NUM_CH; i++) begin : g_stop
        sync_edge u_stop (.clk(clk), .reset(reset), .async_i(stop[i]), .sync_o(stop_sync[i]), .edge_o(stop_edge[i]));
    end

    assign at_to = coarse_q == COARSE_W'(TIMEOUT);

    always_comb begin
        state_d  = state_q;
        coarse_d = coarse_q;
        hit_d    = hit_q;
        lat_d    = lat_q;
        fs_d     = fs_q;
        fst_d    = fst_q;
        settle_d = settle_q;
        ch_d     = ch_q;
        new_hit  = stop_edge & ~hit_q;
        case (state_q)
            IDLE: if (start_edge) begin
                state_d  = RUN;
                coarse_d = '0;
                hit_d    = '0;
            end
            RUN: begin
                hit_d = hit_q | new_hit;
                for (int k = 0; k < NUM_CH; k++)
                    if (new_hit[k]) lat_d[k] = coarse_q;
                coarse_d = at_to ? coarse_q : coarse_q + 1'b1;
                if (&hit_d || at_to) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == 4'(SETTLE_CYC - 1)) begin
                    state_d = EMIT;
                    fs_d    = fine_start;
                    fst_d   = fine_stop;
                    ch_d    = '0;
                end
            end
            EMIT: if (ready) begin
                ch_d = ch_q + 1'b1;
                if (ch_q == CH_W'(NUM_CH - 1)) state_d = REARM;
            end
            REARM: if (!start_sync && !(|stop_sync)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!reset) begin
            state_q  <= IDLE;
            coarse_q <= '0;
            hit_q    <= '0;
            lat_q    <= '0;
            fs_q     <= '0;
            fst_q    <= '0;
            settle_q <= '0;
            ch_q     <= '0;
        end else begin
            state_q  <= state_d;
            coarse_q <= coarse_d;
            hit_q    <= hit_d;
            lat_q    <= lat_d;
            fs_q     <= fs_d;
            fst_q    <= fst_d;
            settle_q <= settle_d;
            ch_q     <= ch_d;
        end

    // Channels that never saw a stop report the timeout value as their coarse time.
    assign data = (state_q == EMIT) ?
        {ch_q, hit_q[ch_q], hit_q[ch_q] ? lat_q[ch_q] : COARSE_W'(TIMEOUT), fs_q, fst_q[ch_q], REC_TAG} : '0;
    assign valid      = state_q == EMIT;
    assign busy       = state_q != IDLE;
    assign fine_clear = (state_q == REARM) | ~reset;
endmodule

// File: tb/tb_tdc_multi.sv
// tb_tdc_multi: directed scoreboard bench for tdc_multi (4 channels, TIMEOUT=20).
module tb_tdc_multi;
    localparam int TO = 20;
    logic        clk = 0, reset, start, ready, fine_clear, busy, valid;
    logic [3:0]  stop;
    logic [9:0]  fine_start;
    logic [39:0] fine_stop;
    logic [42:0] data, held;
    logic [42:0] sb[$];
    int n_chk = 0, n_pass = 0;

    tdc_multi #(.NUM_CH(4), .COARSE_W(16), .FINE_W(10), .SETTLE_CYC(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .fine_start(fine_start),
        .fine_stop(fine_stop), .fine_clear(fine_clear), .busy(busy), .data(data),
        .valid(valid), .ready(ready));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [42:0] rec(input int ch, input bit h, input int c,
                                        input logic [9:0] fs, input logic [9:0] fp);
        return {2'(ch), h, h ? 16'(c) : 16'(TO), fs, fp, 4'b0101};
    endfunction

    always @(negedge clk)
        if (reset && valid && ready) begin
            if (sb.size() == 0) chk("unexpected_record", {21'd0, data}, 64'd0);
            else chk("record", {21'd0, data}, {21'd0, sb.pop_front()});
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        @(negedge clk);
        while (!valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {63'd0, valid}, 64'd1);
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        @(negedge clk);
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        @(negedge clk);
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle", {63'd0, busy}, 64'd0);
    endtask

    // cs[i] is the RUN-cycle count at which channel i stops, -1 for no stop.
    task automatic run_meas(input int c0, input int c1, input int c2, input int c3);
        int cs[4];
        int last = 0;
        cs = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            if (cs[i] > last) last = cs[i];
            sb.push_back(rec(i, cs[i] >= 0, cs[i], fine_start, fine_stop[i*10 +: 10]));
        end
        tick;
        start = 1;
        for (int t = 1; t <= last + 1; t++) begin
            tick;
            for (int i = 0; i < 4; i++) if (cs[i] + 1 == t) stop[i] = 1;
        end
    endtask

    task automatic release_all;
        tick;
        start = 0;
        stop  = '0;
        wait_idle(20);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; start = 0; stop = '0; ready = 1;
        fine_start = 10'h155;
        for (int i = 0; i < 4; i++) fine_stop[i*10 +: 10] = 10'h100 + 10'(i * 17);
        repeat (3) tick;
        @(negedge clk);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data", {21'd0, data}, 64'd0);
        chk("rst_fine_clear", {63'd0, fine_clear}, 64'd1);
        tick;
        reset = 1;
        @(negedge clk);
        chk("run_fine_clear", {63'd0, fine_clear}, 64'd0);
        chk("run_busy", {63'd0, busy}, 64'd0);

        // all four channels, back-to-back records, start held high afterwards
        run_meas(5, 7, 9, 11);
        wait_valid(40);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("consecutive_valid", {63'd0, valid}, 64'd1);
        end
        @(negedge clk);
        chk("valid_drop", {63'd0, valid}, 64'd0);
        chk("rearm_fine_clear", {63'd0, fine_clear}, 64'd1);
        repeat (6) @(negedge clk);
        chk("rearm_hold_busy", {63'd0, busy}, 64'd1);
        chk("rearm_hold_fc", {63'd0, fine_clear}, 64'd1);
        chk("sb_empty_1", 64'(sb.size()), 64'd0);
        release_all;
        repeat (4) @(negedge clk);
        chk("no_queued_start", {63'd0, busy}, 64'd0);

        // single hit, remaining channels time out
        fine_start = 10'h2a3;
        fine_stop  = {10'h011, 10'h3fe, 10'h200, 10'h0c7};
        run_meas(-1, -1, 3, -1);
        wait_valid(40);
        wait_drain(10);
        release_all;

        // consumer stalls for 10 cycles
        fine_start = 10'h07e;
        fine_stop  = {10'h155, 10'h2aa, 10'h333, 10'h0cc};
        ready = 0;
        run_meas(2, 4, 6, 8);
        wait_valid(40);
        held = data;
        for (int k = 0; k < 10; k++) begin
            tick;
            @(negedge clk);
            chk("stall_valid", {63'd0, valid}, 64'd1);
            chk("stall_data", {21'd0, data}, {21'd0, held});
        end
        chk("stall_sb", 64'(sb.size()), 64'd4);
        tick;
        ready = 1;
        wait_drain(10);
        release_all;

        // stop coincident with start in IDLE is ignored
        fine_start = 10'h1c1;
        fine_stop  = {10'h004, 10'h003, 10'h002, 10'h001};
        sb.push_back(rec(0, 1, 5, fine_start, fine_stop[9:0]));
        sb.push_back(rec(1, 1, 2, fine_start, fine_stop[19:10]));
        sb.push_back(rec(2, 0, 0, fine_start, fine_stop[29:20]));
        sb.push_back(rec(3, 0, 0, fine_start, fine_stop[39:30]));
        tick;
        start = 1;
        stop[0] = 1;
        for (int t = 1; t <= 6; t++) begin
            tick;
            if (t == 2) stop[0] = 0;
            if (t == 3) stop[1] = 1;
            if (t == 6) stop[0] = 1;
        end
        wait_valid(40);
        wait_drain(10);
        release_all;

        // reset pulse while a record is waiting
        fine_start = 10'h3c3;
        fine_stop  = {10'h0aa, 10'h0bb, 10'h0cc, 10'h0dd};
        ready = 0;
        run_meas(2, 4, 6, 8);
        wait_valid(40);
        tick;
        reset = 0;
        start = 0;
        stop  = '0;
        @(negedge clk);
        chk("mid_rst_fine_clear", {63'd0, fine_clear}, 64'd1);
        tick;
        reset = 1;
        @(negedge clk);
        chk("abort_valid", {63'd0, valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", {63'd0, busy}, 64'd0);
        ready = 1;
        fine_start = 10'h0f0;
        run_meas(1, 2, 3, 4);
        wait_valid(40);
        wait_drain(10);
        release_all;
        chk("sb_final", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tdc_multi.md
TDC_MULTI -- requirements
Module: tdc_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of stop channels (1..16).
REQ-002 SHALL have parameter COARSE_W, default 16, coarse counter width.
REQ-003 SHALL have parameter FINE_W, default 10, fine interpolator code width.
REQ-004 SHALL have parameter SETTLE_CYC, default 2, cycles allowed for fine codes to settle (1..15).
REQ-005 SHALL have parameter TIMEOUT, default 2**COARSE_W-1, coarse count that ends a measurement.
REQ-006 SHALL have ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  asynchronous start level.
stop  in  NUM_CH  asynchronous stop levels, one per channel.
fine_start  in  FINE_W  fine code of the start interpolator.
fine_stop  in  NUM_CH*FINE_W  fine codes; channel i at [i*FINE_W +: FINE_W].
fine_clear  out  1  clears the external interpolators.
busy  out  1  high in every state except IDLE.
data  out  DATA_W  record {ch, hit, coarse, fine_start, fine_stop_i, 4'b0101}.
valid  out  1  record available.
ready  in  1  consumer accepts the record when valid&ready.
REQ-007 SHALL define DATA_W = CH_W+1+COARSE_W+2*FINE_W+4, where CH_W = max(1,clog2(NUM_CH)); the default is 43.

Function
REQ-008 SHALL pass start and each stop through a 2-flop synchroniser; an edge is sync=1 with previous sync=0.
REQ-009 SHALL implement the states IDLE, RUN, SETTLE, EMIT, REARM.
REQ-010 IDLE: a start edge SHALL go to RUN, clear the coarse counter to 0, and clear every hit flag; stop edges in IDLE, including those simultaneous with the start edge, SHALL be ignored.
REQ-011 RUN: the coarse counter SHALL increment by 1 per cycle, starting at 0 on the first RUN cycle, and SHALL saturate at TIMEOUT.
REQ-012 RUN: the first stop edge on channel i SHALL set hit[i] and latch the current coarse value; later edges on that channel SHALL be ignored.
REQ-013 RUN SHALL go to SETTLE when all hit flags are set (including edges arriving that cycle) or when the coarse counter equals TIMEOUT; a stop edge in the TIMEOUT cycle SHALL count as a hit.
REQ-014 SETTLE SHALL last exactly SETTLE_CYC cycles; on its last cycle it SHALL register fine_start and all fine_stop codes, then go to EMIT.
REQ-015 EMIT SHALL present one record per channel in order 0..NUM_CH-1; a channel without a hit SHALL carry hit=0 and coarse=TIMEOUT.
REQ-016 valid SHALL rise on the first EMIT cycle, and data SHALL be stable while valid=1 and ready=0.
REQ-017 On valid&ready, the next channel's record SHALL appear the following cycle with valid held high, giving 1 record/cycle when ready=1.
REQ-018 Acceptance of channel NUM_CH-1 SHALL drop valid the next cycle and go to REARM.
REQ-019 REARM SHALL hold fine_clear=1 and return to IDLE once the synchronised start and all stops are 0.
REQ-020 start edges outside IDLE SHALL be ignored; no measurement is queued.
REQ-021 fine_clear SHALL equal (state==REARM) OR (reset==0), combinationally.

Reset
REQ-022 While reset=0 at a clk edge, the block SHALL enter IDLE, clear valid, data, the coarse counter, the hit flags, the latched codes and the synchronisers to 0, and clear busy.
REQ-023 Reset asserted in any state, including mid-EMIT with valid=1, SHALL abort the measurement with no further records.

Structure
REQ-024 The state encoding, the 4'b0101 record tag and the DATA_W/CH_W derivation functions SHALL reside in a shared package (tdc_pkg).
REQ-025 Synchronise-plus-edge-detect SHALL be one sub-module, sync_edge, instantiated 1+NUM_CH times.

Verification
REQ-026 Defaults; start, then stops on ch0..3 at 5/7/9/11 RUN cycles; ready=1 -> 4 consecutive records, hit=1, coarse 5/7/9/11, tag 0101.
REQ-027 TIMEOUT=20; only ch2 stops at cycle 3 -> ch2 record hit=1, coarse=3; the others hit=0, coarse=20.
REQ-028 ready low for 10 cycles during EMIT -> valid stays high, data unchanged, no record lost or duplicated.
REQ-029 start and stop[0] edges in the same cycle in IDLE -> stop ignored; ch0 hit only from a later edge.
REQ-030 reset=0 for one cycle mid-EMIT -> valid=0 and busy=0 next cycle; the next start yields fresh records.
REQ-031 start held high after the last record -> stays in REARM with fine_clear=1; a new measurement begins only after start falls and rises again.
